// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the multi-cycle integer divider.
package div_pkg;
   typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;
   localparam int MAXW = 64;
   // Operands are passed zero-extended; w selects which bit is the sign.
   function automatic logic [MAXW-1:0] abs_sel(input logic [MAXW-1:0] value, input logic is_signed,
                                                input int w);
      return (is_signed && value[w-1]) ? -value : value;
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on a remainder:quotient pair.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);
   logic [WIDTH:0] sh;
   logic           ge;
   assign sh      = {rem_in, quo_in[WIDTH-1]};
   assign ge      = sh >= {1'b0, divisor};
   assign rem_out = WIDTH'(ge ? sh - {1'b0, divisor} : sh);
   assign quo_out = {quo_in[WIDTH-2:0], ge};
endmodule

// File: rtl/mc_divider.sv
// mc_divider: iterative restoring divide/remainder unit with RISC-V M semantics
// and an active-low pipeline stall output.
module mc_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SPC   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             n_stall,
   input  logic             flush,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic [WIDTH-1:0] res,
   output logic             res_valid,
   output logic             div_nstall,
   output logic             busy
);
   localparam int N  = WIDTH / SPC;
   localparam int CW = $clog2(N + 1);
   div_state_t       state_q, state_d;
   div_op_t          op_q, op_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_c [SPC+1];
   logic [WIDTH-1:0] quo_c [SPC+1];
   logic             in_signed;
   logic [WIDTH-1:0] q_fix, r_fix;
   assign rem_c[0] = rem_q;
   assign quo_c[0] = quo_q;
   for (genvar i = 0; i < SPC; i++) begin : g_step
      div_step #(.WIDTH(WIDTH)) u_step (
         .rem_in (rem_c[i]),
         .quo_in (quo_c[i]),
         .divisor(dvs_q),
         .rem_out(rem_c[i+1]),
         .quo_out(quo_c[i+1])
      );
   end
   assign in_signed = ~op[0];
   assign q_fix     = qneg_q ? -quo_q : quo_q;
   assign r_fix     = rneg_q ? -rem_q : rem_q;
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (start && !flush) begin
            op_d   = div_op_t'(op);
            qneg_d = in_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
            rneg_d = in_signed & op1[WIDTH-1];
            rem_d  = '0;
            quo_d  = WIDTH'(abs_sel(MAXW'(op1), in_signed, WIDTH));
            dvs_d  = WIDTH'(abs_sel(MAXW'(op2), in_signed, WIDTH));
            if (op2 == '0) begin
               res_d   = op[1] ? op1 : '1;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d   = CW'(N);
               state_d = ITER;
            end
         end
         ITER: begin
            rem_d   = rem_c[SPC];
            quo_d   = quo_c[SPC];
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == CW'(1)) ? FIX : ITER;
         end
         FIX: begin
            res_d   = op_q[1] ? r_fix : q_fix;
            state_d = DONE;
         end
         default: state_d = n_stall ? IDLE : DONE;
      endcase
      // A mispredict kills whatever is in flight, including a held result.
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= DIV;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         cnt_q   <= cnt_d;
      end
   end
   assign res        = res_q;
   assign res_valid  = state_q == DONE;
   assign busy       = state_q != IDLE;
   assign div_nstall = !((state_q == IDLE && start && !flush) || state_q == ITER || state_q == FIX);
endmodule

// File: tb/tb_mc_divider.sv
// tb_mc_divider: directed checks of mc_divider latency, results, flush and stall hold.
module tb_mc_divider;
   import div_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n, n_stall, flush, start1, start4;
   logic [1:0]  op;
   logic [31:0] op1, op2, res1, res4;
   logic        v1, v4, nst1, nst4, busy1, busy4;
   int          checks = 0;
   int          passes = 0;
   always #5 clk = ~clk;
   mc_divider #(.WIDTH(32), .SPC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .n_stall(n_stall), .flush(flush), .start(start1), .op(op),
      .op1(op1), .op2(op2), .res(res1), .res_valid(v1), .div_nstall(nst1), .busy(busy1)
   );
   mc_divider #(.WIDTH(32), .SPC(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .n_stall(n_stall), .flush(flush), .start(start4), .op(op),
      .op1(op1), .op2(op2), .res(res4), .res_valid(v4), .div_nstall(nst4), .busy(busy4)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask
   // Issue one op, count cycles to res_valid and stall-low cycles, check result.
   task automatic run(input string tag, input bit use4, input logic [1:0] o,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int ecyc);
      int cyc = 0;
      int lows = 0;
      bit got = 0;
      @(posedge clk); #1;
      op = o; op1 = a; op2 = b;
      if (use4) start4 = 1'b1; else start1 = 1'b1;
      while (!got && cyc < 100) begin
         @(negedge clk);
         if (!(use4 ? nst4 : nst1)) lows++;
         if (use4 ? v4 : v1) got = 1;
         else begin
            @(posedge clk); #1;
            start1 = 1'b0; start4 = 1'b0;
            cyc++;
         end
      end
      check({tag, " cycle"}, cyc, ecyc);
      check({tag, " res"}, use4 ? res4 : res1, exp);
      check({tag, " stall_cycles"}, lows, ecyc);
   endtask
   initial begin
      int first;
      logic [31:0] r;
      rst_n = 1'b0; n_stall = 1'b1; flush = 1'b0; start1 = 1'b0; start4 = 1'b0;
      op = 2'b00; op1 = '0; op2 = '0;
      #12;
      check("rst res", res1, 32'h0);
      check("rst valid", {31'b0, v1}, 32'h0);
      check("rst busy", {31'b0, busy1}, 32'h0);
      check("rst nstall", {31'b0, nst1}, 32'h1);
      @(negedge clk); rst_n = 1'b1;
      run("div 100/-7", 0, DIV, 32'd100, -32'sd7, 32'hFFFFFFF2, 34);
      run("rem -100/7", 0, REM, -32'sd100, 32'd7, 32'hFFFFFFFE, 34);
      run("remu ffffffff/16", 0, REMU, 32'hFFFFFFFF, 32'd16, 32'd15, 34);
      run("divu 1234/0", 0, DIVU, 32'd1234, 32'd0, 32'hFFFFFFFF, 1);
      run("rem 1234/0", 0, REM, 32'd1234, 32'd0, 32'd1234, 1);
      run("div min/-1", 0, DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
      run("rem min/-1", 0, REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 34);
      // Flush DIV 1000/3 at cycle 10, then start DIV 9/3 at cycle 11.
      @(posedge clk); #1;
      op = DIV; op1 = 32'd1000; op2 = 32'd3; start1 = 1'b1;
      first = -1; r = '0;
      for (int c = 0; c < 60; c++) begin
         if (c == 1) start1 = 1'b0;
         if (c == 10) flush = 1'b1;
         if (c == 11) begin flush = 1'b0; op1 = 32'd9; op2 = 32'd3; start1 = 1'b1; end
         if (c == 12) start1 = 1'b0;
         @(negedge clk);
         if (c == 11) check("flush busy", {31'b0, busy1}, 32'h0);
         if (v1 && first < 0) begin first = c; r = res1; end
         @(posedge clk); #1;
      end
      check("flush next cycle", first, 45);
      check("flush next res", r, 32'd3);
      run("spc4 divu", 1, DIVU, 32'hDEADBEEF, 32'h1234, 32'h000C3BA5, 10);
      n_stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold valid", {31'b0, v4}, 32'h1);
         check("hold res", res4, 32'h000C3BA5);
      end
      n_stall = 1'b1;
      run("spc4 remu", 1, REMU, 32'hDEADBEEF, 32'h1234, 32'h0000076B, 10);
      run("spc4 div", 1, DIV, 32'd100, -32'sd7, 32'hFFFFFFF2, 10);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
